// File: rtl/hazard_stall_unit.sv
// Producer-side hazard control for the 5-stage LC-3b pipeline: load-use bubbles,
// data-memory wait freezes and LDI/STI double-access sequencing, plus saturating stall counters.
module hazard_stall_unit #(
  parameter int CNT_W = 16,
  parameter int LU_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       ifid_opcode,
  input  logic [2:0]       ifid_src1,
  input  logic [2:0]       ifid_src2,
  input  logic             ifid_bit5,
  input  logic             ifid_bit11,
  input  logic [3:0]       idex_opcode,
  input  logic [2:0]       idex_dest,
  input  logic             idex_ld_dest,
  input  logic [3:0]       exme_opcode,
  input  logic             dmem_read,
  input  logic             dmem_write,
  input  logic             dmem_resp,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_bubble,
  output logic             pipe_stall,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [LU_W-1:0]  lu_events
);

  localparam logic [3:0] OP_ADD = 4'd1,  OP_LDB = 4'd2,  OP_STB = 4'd3,  OP_JSR = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5,  OP_LDR = 4'd6,  OP_STR = 4'd7,  OP_NOT = 4'd9;
  localparam logic [3:0] OP_LDI = 4'd10, OP_STI = 4'd11, OP_JMP = 4'd12, OP_SHF = 4'd13;

  typedef enum logic [1:0] {RUN, MEM_WAIT, IND_WAIT} state_t;

  state_t state, state_next;
  logic   ind_first, ind_first_next;
  logic   use1, use2, loaduse, memop, ind_op, stall_raw, bubble_raw;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    use1 = 1'b0;
    use2 = 1'b0;
    case (ifid_opcode)
      OP_ADD, OP_AND: begin use1 = 1'b1; use2 = ~ifid_bit5; end
      OP_JSR:         use1 = ~ifid_bit11;
      OP_NOT, OP_JMP, OP_SHF, OP_LDB, OP_LDR, OP_LDI: use1 = 1'b1;
      OP_STB, OP_STR, OP_STI: begin use1 = 1'b1; use2 = 1'b1; end
      default: ;
    endcase
  end

  assign loaduse = (idex_opcode == OP_LDB || idex_opcode == OP_LDR || idex_opcode == OP_LDI)
                 && idex_ld_dest
                 && ((use1 && idex_dest == ifid_src1) || (use2 && idex_dest == ifid_src2));

  assign memop  = dmem_read | dmem_write;
  assign ind_op = (exme_opcode == OP_LDI) || (exme_opcode == OP_STI);

  always_comb begin
    state_next     = state;
    ind_first_next = ind_first;
    stall_raw      = 1'b0;
    case (state)
      RUN: begin
        if (memop && ind_op) begin
          // The first access of LDI/STI never releases the pipe, even with an immediate response.
          stall_raw      = 1'b1;
          ind_first_next = ~dmem_resp;
          state_next     = dmem_resp ? IND_WAIT : MEM_WAIT;
        end else if (memop) begin
          stall_raw      = ~dmem_resp;
          ind_first_next = 1'b0;
          if (!dmem_resp) state_next = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        stall_raw = ind_first | ~dmem_resp;
        if (dmem_resp) begin
          state_next     = ind_first ? IND_WAIT : RUN;
          ind_first_next = 1'b0;
        end
      end
      IND_WAIT: begin
        stall_raw = ~dmem_resp;
        if (dmem_resp) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  // A frozen pipe holds the load in EX, so the bubble is deferred to the first unfrozen cycle.
  assign bubble_raw  = loaduse & ~stall_raw;
  assign pipe_stall  = stall_raw & ~rst;
  assign idex_bubble = bubble_raw & ~rst;
  assign pc_stall    = pipe_stall | idex_bubble;
  assign ifid_stall  = pc_stall;

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      ind_first    <= 1'b0;
      stall_cycles <= '0;
      lu_events    <= '0;
    end else begin
      state     <= state_next;
      ind_first <= ind_first_next;
      if (pc_stall && stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
      if (idex_bubble && lu_events != '1) lu_events <= lu_events + LU_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: a responses-outstanding reference model checked
// every cycle, directed scenarios with explicit expectations, then randomized traffic.
module tb_hazard_stall_unit;

  localparam int CNT_W = 10;
  localparam int LU_W  = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int LU_MAX  = (1 << LU_W) - 1;

  localparam logic [3:0] BR = 0, ADD = 1, LDB = 2, STB = 3, JSR = 4, AND_ = 5, LDR = 6, STR = 7;
  localparam logic [3:0] NOT_ = 9, LDI = 10, STI = 11, JMP = 12, SHF = 13, LEA = 14;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] ifid_opcode, idex_opcode, exme_opcode;
  logic [2:0] ifid_src1, ifid_src2, idex_dest;
  logic ifid_bit5, ifid_bit11, idex_ld_dest, dmem_read, dmem_write, dmem_resp;
  logic pc_stall, ifid_stall, idex_bubble, pipe_stall;
  logic [CNT_W-1:0] stall_cycles;
  logic [LU_W-1:0]  lu_events;

  hazard_stall_unit #(.CNT_W(CNT_W), .LU_W(LU_W)) dut (
    .clk(clk), .rst(rst),
    .ifid_opcode(ifid_opcode), .ifid_src1(ifid_src1), .ifid_src2(ifid_src2),
    .ifid_bit5(ifid_bit5), .ifid_bit11(ifid_bit11),
    .idex_opcode(idex_opcode), .idex_dest(idex_dest), .idex_ld_dest(idex_ld_dest),
    .exme_opcode(exme_opcode), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_resp(dmem_resp),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_bubble(idex_bubble),
    .pipe_stall(pipe_stall), .stall_cycles(stall_cycles), .lu_events(lu_events)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: responses still owed by the instruction in MEM, plus counters.
  int need   = 0;
  int m_stall = 0;
  int m_lu    = 0;
  bit e_pipe, e_lu;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit reads_reg(input logic [2:0] r);
    bit u1, u2;
    u1 = 0; u2 = 0;
    case (ifid_opcode)
      ADD, AND_: begin u1 = 1; u2 = !ifid_bit5; end
      JSR: u1 = !ifid_bit11;
      NOT_, JMP, SHF, LDB, LDR, LDI: u1 = 1;
      STB, STR, STI: begin u1 = 1; u2 = 1; end
      default: ;
    endcase
    return (u1 && ifid_src1 == r) || (u2 && ifid_src2 == r);
  endfunction

  // Called at the falling edge: compare against model, then advance the model one cycle.
  task automatic eval();
    int req;
    bit lu_hit;
    @(negedge clk);
    if (need > 0) req = need;
    else if (dmem_read || dmem_write) req = (exme_opcode == LDI || exme_opcode == STI) ? 2 : 1;
    else req = 0;
    lu_hit = (idex_opcode == LDB || idex_opcode == LDR || idex_opcode == LDI)
             && idex_ld_dest && reads_reg(idex_dest);
    e_pipe = (req > 0) && !(dmem_resp && req == 1) && !rst;
    e_lu   = lu_hit && !e_pipe && !rst;
    check("pipe_stall",   int'(pipe_stall),  int'(e_pipe));
    check("idex_bubble",  int'(idex_bubble), int'(e_lu));
    check("pc_stall",     int'(pc_stall),    int'(e_pipe | e_lu));
    check("ifid_stall",   int'(ifid_stall),  int'(e_pipe | e_lu));
    check("stall_cycles", int'(stall_cycles), m_stall);
    check("lu_events",    int'(lu_events),    m_lu);
    if (rst) begin
      need = 0; m_stall = 0; m_lu = 0;
    end else begin
      need = (req > 0 && dmem_resp) ? req - 1 : req;
      if ((e_pipe || e_lu) && m_stall < CNT_MAX) m_stall++;
      if (e_lu && m_lu < LU_MAX) m_lu++;
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0;
    ifid_opcode = BR; ifid_src1 = 0; ifid_src2 = 0; ifid_bit5 = 0; ifid_bit11 = 1;
    idex_opcode = BR; idex_dest = 0; idex_ld_dest = 0;
    exme_opcode = BR; dmem_read = 0; dmem_write = 0; dmem_resp = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    eval(); adv();
    rst = 0;
  endtask

  // LDR R1 in EX with an ADD R2,R1,R3 (register form) in decode.
  task automatic set_loaduse();
    idex_opcode = LDR; idex_dest = 1; idex_ld_dest = 1;
    ifid_opcode = ADD; ifid_src1 = 1; ifid_src2 = 3; ifid_bit5 = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    eval(); adv();
    rst = 0;
    eval();
    check("reset stall_cycles", int'(stall_cycles), 0);
    check("reset lu_events", int'(lu_events), 0);
    check("reset pipe_stall", int'(pipe_stall), 0);
    adv();

    // Load-use with register-form ADD: one bubble, one count.
    do_reset();
    set_loaduse();
    eval();
    check("lu bubble", int'(idex_bubble), 1);
    check("lu pc_stall", int'(pc_stall), 1);
    adv();
    idle();
    eval();
    check("lu one cycle", int'(idex_bubble), 0);
    check("lu_events one", int'(lu_events), 1);
    adv();

    // Immediate-form ADD whose imm bits alias R1 in src2: no hazard.
    idex_opcode = LDR; idex_dest = 1; idex_ld_dest = 1;
    ifid_opcode = ADD; ifid_src1 = 3; ifid_src2 = 1; ifid_bit5 = 1;
    eval();
    check("imm no bubble", int'(idex_bubble), 0);
    check("imm no pc_stall", int'(pc_stall), 0);
    adv();

    // LDR in MEM, response on the fourth cycle.
    do_reset();
    exme_opcode = LDR; dmem_read = 1;
    for (int i = 0; i < 4; i++) begin
      dmem_resp = (i == 3);
      eval();
      check("ldr pipe_stall", int'(pipe_stall), (i < 3) ? 1 : 0);
      adv();
    end
    idle();
    eval();
    check("ldr stall_cycles", int'(stall_cycles), 3);
    adv();

    // LDI: responses on cycles 2 and 5.
    do_reset();
    exme_opcode = LDI; dmem_read = 1;
    for (int i = 0; i < 6; i++) begin
      dmem_resp = (i == 2 || i == 5);
      eval();
      check("ldi pipe_stall", int'(pipe_stall), (i < 5) ? 1 : 0);
      adv();
    end
    idle();
    eval();
    check("ldi back to run", int'(pipe_stall), 0);
    check("ldi stall_cycles", int'(stall_cycles), 5);
    adv();

    // Load-use while a plain load waits in MEM: bubble only on the response cycle.
    do_reset();
    set_loaduse();
    exme_opcode = LDR; dmem_read = 1;
    for (int i = 0; i < 3; i++) begin
      dmem_resp = (i == 2);
      eval();
      check("frozen bubble", int'(idex_bubble), (i == 2) ? 1 : 0);
      adv();
    end

    // Reset while in the indirect second access, then a fresh LDI needs both responses.
    do_reset();
    exme_opcode = STI; dmem_write = 1; dmem_resp = 1;
    eval(); adv();
    dmem_resp = 0;
    eval(); adv();
    rst = 1;
    set_loaduse();
    eval();
    check("rst pipe_stall", int'(pipe_stall), 0);
    check("rst bubble", int'(idex_bubble), 0);
    adv();
    idle();
    eval();
    check("rst counters", int'(stall_cycles), 0);
    adv();
    exme_opcode = LDI; dmem_read = 1; dmem_resp = 1;
    eval();
    check("restart first resp", int'(pipe_stall), 1);
    adv();
    eval();
    check("restart second resp", int'(pipe_stall), 0);
    adv();

    // Load-use counter saturation.
    do_reset();
    set_loaduse();
    for (int i = 0; i < (1 << LU_W) + 3; i++) begin eval(); adv(); end
    idle();
    eval();
    check("lu_events saturate", int'(lu_events), LU_MAX);
    adv();

    // Stall counter saturation with a never-answered read.
    do_reset();
    exme_opcode = LDR; dmem_read = 1;
    for (int i = 0; i < CNT_MAX + 5; i++) begin eval(); adv(); end
    dmem_resp = 1;
    eval(); adv();
    idle();
    eval();
    check("stall_cycles saturate", int'(stall_cycles), CNT_MAX);
    adv();

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 99) == 0);
      ifid_opcode  = 4'($urandom_range(0, 15));
      ifid_src1    = 3'($urandom_range(0, 3));
      ifid_src2    = 3'($urandom_range(0, 3));
      ifid_bit5    = 1'($urandom_range(0, 1));
      ifid_bit11   = 1'($urandom_range(0, 1));
      idex_opcode  = ($urandom_range(0, 1) == 0) ? LDR : 4'($urandom_range(0, 15));
      idex_dest    = 3'($urandom_range(0, 3));
      idex_ld_dest = ($urandom_range(0, 3) != 0);
      exme_opcode  = ($urandom_range(0, 2) == 0) ? LDI : 4'($urandom_range(0, 15));
      dmem_read    = ($urandom_range(0, 3) == 0);
      dmem_write   = ($urandom_range(0, 7) == 0);
      dmem_resp    = ($urandom_range(0, 2) == 0);
      eval();
      adv();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
